ddc_cfg_sequencer: RTL and testbench

DDC_CFG_SEQUENCER -- requirements
Module: ddc_cfg_sequencer

---
 rtl/ddc_ctrl_pkg.sv | 23 ++
 rtl/cycle_timer.sv | 25 ++
 rtl/ddc_cfg_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ddc_cfg_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_ctrl_pkg.sv
// Shared types and constants for the DDC reconfiguration sequencer.
// Register offsets are relative to the DDC's settings base address.
package ddc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_WR0,
    ST_WR1,
    ST_WR2,
    ST_WR3,
    ST_CLR,
    ST_SETTLE
  } state_t;

  localparam logic [7:0] REG_PHASE = 8'd0;
  localparam logic [7:0] REG_SCALE = 8'd1;
  localparam logic [7:0] REG_DECIM = 8'd2;
  localparam logic [7:0] REG_MODE  = 8'd3;

  localparam int TIMER_W = 16;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expire is high while the count is zero.
// Loading N-1 therefore gives an N-cycle interval.
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else if (dec)  count <= count - 1'b1;
  end

  assign expire = (count == '0);

endmodule

// File: rtl/ddc_cfg_sequencer.sv
// Safely reprograms a running DDC: drain, write four registers, clear, settle.
// Host settings writes are merged onto the same settings bus via a one-entry hold.
module ddc_cfg_sequencer
  import ddc_ctrl_pkg::*;
#(
  parameter int BASE          = 0,
  parameter int DRAIN_CYCLES  = 64,
  parameter int SETTLE_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_stb,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_phase_inc,
  input  logic [17:0] cfg_scale,
  input  logic [9:0]  cfg_decim,
  input  logic [1:0]  cfg_mode,
  input  logic        run_in,
  output logic        run_out,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        ddc_clr,
  output logic        busy,
  output logic        done,
  output logic        host_ovf
);

  localparam logic [7:0] BASE8 = 8'(BASE);

  state_t      state, state_nxt;
  logic [31:0] phase_q;
  logic [17:0] scale_q;
  logic [9:0]  decim_q;
  logic [1:0]  mode_q;

  logic        hold_full, hold_full_nxt;
  logic [7:0]  hold_addr, hold_addr_nxt;
  logic [31:0] hold_data, hold_data_nxt;
  logic        ovf_set;

  logic        emit_stb;
  logic [7:0]  emit_addr;
  logic [31:0] emit_data;

  logic                 accept;
  logic                 tmr_load, tmr_dec, tmr_expire;
  logic [TIMER_W-1:0]   tmr_val;

  assign accept = cfg_valid & cfg_ready;

  cycle_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expire   (tmr_expire)
  );

  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state)
      ST_IDLE: if (accept) begin
        state_nxt = ST_DRAIN;
        tmr_load  = 1'b1;
        tmr_val   = TIMER_W'(DRAIN_CYCLES - 1);
      end
      ST_DRAIN:  if (tmr_expire) state_nxt = ST_WR0;
      ST_WR0:    state_nxt = ST_WR1;
      ST_WR1:    state_nxt = ST_WR2;
      ST_WR2:    state_nxt = ST_WR3;
      ST_WR3:    state_nxt = ST_CLR;
      ST_CLR: begin
        state_nxt = ST_SETTLE;
        tmr_load  = 1'b1;
        tmr_val   = TIMER_W'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: if (tmr_expire) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    tmr_dec = (state == ST_DRAIN || state == ST_SETTLE) && !tmr_expire;
  end

  // A held write is shown on set_* during its first IDLE cycle and dropped
  // from the hold at the end of it, unless a new host write replaces it.
  always_comb begin
    hold_full_nxt = hold_full;
    hold_addr_nxt = hold_addr;
    hold_data_nxt = hold_data;
    ovf_set       = 1'b0;
    if (state == ST_IDLE) begin
      if (hold_full && host_stb) begin
        hold_addr_nxt = host_addr;
        hold_data_nxt = host_data;
      end else if (hold_full) begin
        hold_full_nxt = 1'b0;
      end
    end else if (host_stb) begin
      if (!hold_full) begin
        hold_full_nxt = 1'b1;
        hold_addr_nxt = host_addr;
        hold_data_nxt = host_data;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  always_comb begin
    emit_stb  = 1'b0;
    emit_addr = set_addr;
    emit_data = set_data;
    unique case (state_nxt)
      ST_WR0: begin emit_stb = 1'b1; emit_addr = BASE8 + REG_PHASE; emit_data = phase_q; end
      ST_WR1: begin emit_stb = 1'b1; emit_addr = BASE8 + REG_SCALE; emit_data = {14'b0, scale_q}; end
      ST_WR2: begin emit_stb = 1'b1; emit_addr = BASE8 + REG_DECIM; emit_data = {22'b0, decim_q}; end
      ST_WR3: begin emit_stb = 1'b1; emit_addr = BASE8 + REG_MODE;  emit_data = {30'b0, mode_q}; end
      default: begin
        if (state == ST_IDLE && !hold_full && host_stb) begin
          emit_stb  = 1'b1;
          emit_addr = host_addr;
          emit_data = host_data;
        end else if (state_nxt == ST_IDLE && hold_full_nxt) begin
          emit_stb  = 1'b1;
          emit_addr = hold_addr_nxt;
          emit_data = hold_data_nxt;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      cfg_ready <= 1'b1;
      run_out   <= 1'b0;
      set_stb   <= 1'b0;
      set_addr  <= '0;
      set_data  <= '0;
      ddc_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      host_ovf  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_full <= hold_full_nxt;
      cfg_ready <= (state_nxt == ST_IDLE) && !hold_full_nxt;
      run_out   <= run_in && (state == ST_IDLE) && !accept;
      set_stb   <= emit_stb;
      set_addr  <= emit_addr;
      set_data  <= emit_data;
      ddc_clr   <= (state_nxt == ST_CLR);
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state == ST_SETTLE) && tmr_expire;
      if (ovf_set) host_ovf <= 1'b1;
    end
  end

  // NOTE: datapath registers carry no reset; hold_full and state qualify their use.
  always_ff @(posedge clk) begin
    hold_addr <= hold_addr_nxt;
    hold_data <= hold_data_nxt;
    if (accept) begin
      phase_q <= cfg_phase_inc;
      scale_q <= cfg_scale;
      decim_q <= cfg_decim;
      mode_q  <= cfg_mode;
    end
  end

endmodule

// File: tb/tb_ddc_cfg_sequencer.sv
// Scoreboard bench for ddc_cfg_sequencer with BASE=8, DRAIN=4, SETTLE=3.
// Stimulus pushes expected settings writes; a negedge monitor pops and compares them.
module tb_ddc_cfg_sequencer;

  localparam int BASE = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_stb;
  logic [7:0]  host_addr;
  logic [31:0] host_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_phase_inc;
  logic [17:0] cfg_scale;
  logic [9:0]  cfg_decim;
  logic [1:0]  cfg_mode;
  logic        run_in;
  logic        run_out;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        ddc_clr;
  logic        busy;
  logic        done;
  logic        host_ovf;

  ddc_cfg_sequencer #(.BASE(BASE), .DRAIN_CYCLES(4), .SETTLE_CYCLES(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_stb      (host_stb),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_scale     (cfg_scale),
    .cfg_decim     (cfg_decim),
    .cfg_mode      (cfg_mode),
    .run_in        (run_in),
    .run_out       (run_out),
    .set_stb       (set_stb),
    .set_addr      (set_addr),
    .set_data      (set_data),
    .ddc_clr       (ddc_clr),
    .busy          (busy),
    .done          (done),
    .host_ovf      (host_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   c0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issues a request in the current cycle (cycle 0) and queues the first nwr register writes.
  task automatic start_seq(input logic [31:0] ph, input logic [17:0] sc,
                           input logic [9:0] dc, input logic [1:0] md, input int nwr);
    logic [31:0] d [4];
    check("cfg_ready_before_accept", 64'(cfg_ready), 64'd1);
    c0 = cyc;
    cfg_valid     = 1'b1;
    cfg_phase_inc = ph;
    cfg_scale     = sc;
    cfg_decim     = dc;
    cfg_mode      = md;
    d[0] = ph;
    d[1] = {14'b0, sc};
    d[2] = {22'b0, dc};
    d[3] = {30'b0, md};
    for (int k = 0; k < nwr; k++) push(c0 + 5 + k, 8'(BASE + k), d[k]);
  endtask

  always @(negedge clk) begin
    if (set_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL set_unexpected: got addr=0x%0h data=0x%0h at cycle %0d, expected no write",
                 set_addr, set_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("set_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("set_addr", 64'(set_addr), 64'(mon_e.addr));
        check("set_data", 64'(set_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; host_stb = 1'b0; host_addr = '0; host_data = '0;
    cfg_valid = 1'b0; cfg_phase_inc = '0; cfg_scale = '0; cfg_decim = '0; cfg_mode = '0;
    run_in = 1'b0;
    repeat (3) tick();
    check("rst_set_stb", 64'(set_stb), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_run_out", 64'(run_out), 64'd0);
    check("rst_ddc_clr", 64'(ddc_clr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_set_addr", 64'(set_addr), 64'd0);
    check("rst_set_data", 64'(set_data), 64'd0);
    check("rst_host_ovf", 64'(host_ovf), 64'd0);
    rst = 1'b0;
    run_in = 1'b1;
    tick();
    check("idle_cfg_ready", 64'(cfg_ready), 64'd1);

    // Full sequence with run_in held high.
    start_seq(32'h12345678, 18'h1ABCD, 10'h3F8, 2'd2, 4);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) begin
        cfg_valid = 1'b0;
        check("s1_cfg_ready_c1", 64'(cfg_ready), 64'd0);
      end
      check($sformatf("s1_run_out_c%0d", k), 64'(run_out), 64'(k == 14));
      check($sformatf("s1_ddc_clr_c%0d", k), 64'(ddc_clr), 64'(k == 9));
      check($sformatf("s1_done_c%0d", k), 64'(done), 64'(k == 13));
      check($sformatf("s1_busy_c%0d", k), 64'(busy), 64'(k <= 12));
    end

    // Idle host write passes straight through.
    tick();
    host_stb = 1'b1; host_addr = 8'h20; host_data = 32'hDEADBEEF;
    push(cyc + 1, 8'h20, 32'hDEADBEEF);
    tick();
    host_stb = 1'b0;
    tick();

    // Host write during DRAIN is held until the sequence completes.
    start_seq(32'h00000100, 18'h3FFFF, 10'h005, 2'd1, 4);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) cfg_valid = 1'b0;
      if (k == 2) begin
        host_stb = 1'b1; host_addr = 8'h30; host_data = 32'hCAFE0001;
        push(c0 + 13, 8'h30, 32'hCAFE0001);
      end
      if (k == 3) host_stb = 1'b0;
      if (k == 13) begin
        check("s3_cfg_ready_c13", 64'(cfg_ready), 64'd0);
        check("s3_done_c13", 64'(done), 64'd1);
      end
      if (k == 14) check("s3_cfg_ready_c14", 64'(cfg_ready), 64'd1);
    end
    tick();

    // Second write while the hold is full is dropped and flagged.
    start_seq(32'hA5A5A5A5, 18'h00001, 10'h2FF, 2'd3, 4);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) cfg_valid = 1'b0;
      if (k == 2) begin
        host_stb = 1'b1; host_addr = 8'h30; host_data = 32'h11111111;
        push(c0 + 13, 8'h30, 32'h11111111);
      end
      if (k == 3) begin
        host_addr = 8'h31; host_data = 32'h22222222;
        check("s4_ovf_c3", 64'(host_ovf), 64'd0);
      end
      if (k == 4) begin
        host_stb = 1'b0;
        check("s4_ovf_c4", 64'(host_ovf), 64'd1);
      end
      if (k == 13 || k == 16) check($sformatf("s4_ovf_c%0d", k), 64'(host_ovf), 64'd1);
    end

    // Reset in the middle of the register writes aborts the sequence.
    start_seq(32'h0BADF00D, 18'h12345, 10'h155, 2'd0, 2);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) cfg_valid = 1'b0;
      if (k == 6) rst = 1'b1;
      if (k == 7) begin
        rst = 1'b0;
        check("s5_set_stb_c7", 64'(set_stb), 64'd0);
        check("s5_busy_c7", 64'(busy), 64'd0);
        check("s5_run_out_c7", 64'(run_out), 64'd0);
        check("s5_cfg_ready_c7", 64'(cfg_ready), 64'd1);
        check("s5_host_ovf_c7", 64'(host_ovf), 64'd0);
      end
      if (k == 10) check("s5_busy_c10", 64'(busy), 64'd0);
    end

    // run_in low at completion; cfg_valid held high during the sequence.
    run_in = 1'b0;
    tick();
    tick();
    start_seq(32'h00000001, 18'h00002, 10'h003, 2'd1, 4);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 13) cfg_valid = 1'b0;
      check($sformatf("s6_run_out_c%0d", k), 64'(run_out), 64'd0);
      check($sformatf("s6_busy_c%0d", k), 64'(busy), 64'(k <= 12));
      if (k == 13) check("s6_done_c13", 64'(done), 64'd1);
    end

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
